// File: rtl/uart_boot_ctrl.sv
// UART boot loader: parses a sync/addr/count/data/checksum frame from a byte
// receiver, writes words into instruction memory and releases the cores on success.
module uart_boot_ctrl #(
  parameter int CLKS_PER_BIT   = 87,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  output logic [7:0]  o_Clks_Per_Bit,
  output logic        o_Mem_We,
  output logic [31:0] o_Mem_Addr,
  output logic [31:0] o_Mem_Wdata,
  output logic        o_Core_Rst,
  output logic        o_Boot_Done,
  output logic        o_Err
);

  localparam int            GW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_MAX = GW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    SYNC    = 8'hA5;

  typedef enum logic [2:0] {IDLE, ADDR, CNT, DATA, CSUM, DONE} state_t;

  state_t        r_State;
  logic [1:0]    r_Byte_Idx;
  logic [7:0]    r_Xor;
  logic [15:0]   r_Cnt;
  logic [15:0]   r_Word_Idx;
  logic [31:0]   r_Word;
  logic [31:0]   r_Next_Addr;
  logic [GW-1:0] r_Gap;
  logic          r_Mem_We;
  logic [31:0]   r_Mem_Addr;
  logic [31:0]   r_Mem_Wdata;
  logic          r_Core_Rst;
  logic          r_Boot_Done;
  logic          r_Err;

  logic          w_Active;
  logic          w_Timeout;
  logic [31:0]   w_Word;
  logic [15:0]   w_Cnt;
  logic [7:0]    w_Xor;

  assign o_Clks_Per_Bit = 8'(CLKS_PER_BIT);
  assign o_Mem_We       = r_Mem_We;
  assign o_Mem_Addr     = r_Mem_Addr;
  assign o_Mem_Wdata    = r_Mem_Wdata;
  assign o_Core_Rst     = r_Core_Rst;
  assign o_Boot_Done    = r_Boot_Done;
  assign o_Err          = r_Err;

  // Gap counting only matters while a frame is open; a byte arriving on the
  // expiry cycle wins over the timeout.
  assign w_Active  = (r_State == ADDR) || (r_State == CNT) ||
                     (r_State == DATA) || (r_State == CSUM);
  assign w_Timeout = w_Active && !i_Rx_DV && (r_Gap == GAP_MAX);

  // Little-endian assembly: each new byte enters at the top and shifts down.
  assign w_Word = {i_Rx_Byte, r_Word[31:8]};
  assign w_Cnt  = {i_Rx_Byte, r_Cnt[15:8]};
  assign w_Xor  = r_Xor ^ i_Rx_Byte;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_State     <= IDLE;
      r_Byte_Idx  <= '0;
      r_Xor       <= '0;
      r_Cnt       <= '0;
      r_Word_Idx  <= '0;
      r_Word      <= '0;
      r_Next_Addr <= '0;
      r_Gap       <= '0;
      r_Mem_We    <= 1'b0;
      r_Mem_Addr  <= '0;
      r_Mem_Wdata <= '0;
      r_Core_Rst  <= 1'b1;
      r_Boot_Done <= 1'b0;
      r_Err       <= 1'b0;
    end else begin
      r_Mem_We <= 1'b0;

      if (!w_Active || i_Rx_DV || w_Timeout) r_Gap <= '0;
      else                                   r_Gap <= r_Gap + GW'(1);

      if (w_Timeout) begin
        r_State <= IDLE;
        r_Err   <= 1'b1;
      end else if (i_Rx_DV) begin
        case (r_State)
          IDLE: begin
            if (i_Rx_Byte == SYNC) begin
              r_State    <= ADDR;
              r_Err      <= 1'b0;
              r_Xor      <= '0;
              r_Byte_Idx <= '0;
              r_Word_Idx <= '0;
            end
          end
          ADDR: begin
            r_Xor       <= w_Xor;
            r_Next_Addr <= {i_Rx_Byte, r_Next_Addr[31:8]};
            r_Byte_Idx  <= r_Byte_Idx + 2'd1;
            if (r_Byte_Idx == 2'd3) r_State <= CNT;
          end
          CNT: begin
            r_Xor      <= w_Xor;
            r_Cnt      <= w_Cnt;
            r_Byte_Idx <= r_Byte_Idx + 2'd1;
            if (r_Byte_Idx == 2'd1) begin
              r_Byte_Idx <= '0;
              r_State    <= (w_Cnt == 16'd0) ? CSUM : DATA;
            end
          end
          DATA: begin
            r_Xor      <= w_Xor;
            r_Word     <= w_Word;
            r_Byte_Idx <= r_Byte_Idx + 2'd1;
            if (r_Byte_Idx == 2'd3) begin
              r_Mem_We    <= 1'b1;
              r_Mem_Addr  <= r_Next_Addr;
              r_Mem_Wdata <= w_Word;
              r_Next_Addr <= r_Next_Addr + 32'd4;
              r_Word_Idx  <= r_Word_Idx + 16'd1;
              if (r_Word_Idx == r_Cnt - 16'd1) r_State <= CSUM;
            end
          end
          CSUM: begin
            if (i_Rx_Byte == r_Xor) begin
              r_Boot_Done <= 1'b1;
              r_Core_Rst  <= 1'b0;
              r_State     <= DONE;
            end else begin
              r_Err   <= 1'b1;
              r_State <= IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
